// File: rtl/decode_issue.sv
// decode_issue: RV32I decode-and-issue stage feeding the ALU/memory backend.
// Decodes one instruction per transfer into active-low one-hot controls and
// registers it, together with its operands, in a single issue register.
// A one-bubble interlock protects a dependent instruction that follows a load.
// Optional build macro: DECODE_ISSUE_SKID_EN adds a one-entry skid buffer so
// that inst_ready is a registered signal.
module decode_issue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    input  logic [31:0] inst_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  alu_op,
    output logic [7:0]  mem_op,
    output logic        load,
    output logic        store,
    output logic [31:0] alu_opr_1,
    output logic [31:0] alu_opr_2,
    output logic [31:0] store_data,
    output logic [4:0]  rd,
    output logic        wb_en,
    output logic [2:0]  br_type,
    output logic        br_en,
    output logic        jmp_en,
    output logic [31:0] br_target,
    output logic        illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // alu_op = {slt_n, sltu_n, sll_n, srl_n, sra_n, 74x381 select[2:0]}
    localparam logic [7:0] ALU_NOP  = 8'hFF;
    localparam logic [7:0] ALU_ADD  = 8'hFB;
    localparam logic [7:0] ALU_SUB  = 8'hFA;
    localparam logic [7:0] ALU_XOR  = 8'hFC;
    localparam logic [7:0] ALU_OR   = 8'hFD;
    localparam logic [7:0] ALU_AND  = 8'hFE;
    localparam logic [7:0] ALU_SLT  = 8'h7A;
    localparam logic [7:0] ALU_SLTU = 8'hBA;
    localparam logic [7:0] ALU_SLL  = 8'hDB;
    localparam logic [7:0] ALU_SRL  = 8'hEB;
    localparam logic [7:0] ALU_SRA  = 8'hF3;

    // mem_op = {lb, lh, lw, lbu, lhu, sb, sh, sw}, all active low
    localparam logic [7:0] MEM_NOP = 8'hFF;
    localparam logic [7:0] MEM_LB  = 8'h7F;
    localparam logic [7:0] MEM_LH  = 8'hBF;
    localparam logic [7:0] MEM_LW  = 8'hDF;
    localparam logic [7:0] MEM_LBU = 8'hEF;
    localparam logic [7:0] MEM_LHU = 8'hF7;
    localparam logic [7:0] MEM_SB  = 8'hFB;
    localparam logic [7:0] MEM_SH  = 8'hFD;
    localparam logic [7:0] MEM_SW  = 8'hFE;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [7:0]  alu_op;
        logic [7:0]  mem_op;
        logic        load;
        logic        store;
        logic        a_pc;       // operand A comes from the held pc
        logic [31:0] opr1;
        logic [31:0] opr2;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        wb_en;
        logic [2:0]  br_type;
        logic        br_en;
        logic        jmp_en;
        logic [31:0] br_target;
        logic        illegal;
    } issue_t;

    localparam issue_t ISSUE_BUBBLE = '{
        valid: 1'b0, alu_op: ALU_NOP, mem_op: MEM_NOP, load: 1'b1, store: 1'b1,
        a_pc: 1'b0, opr1: 32'd0, opr2: 32'd0, store_data: 32'd0, rd: 5'd0,
        wb_en: 1'b0, br_type: 3'd0, br_en: 1'b0, jmp_en: 1'b0,
        br_target: 32'd0, illegal: 1'b0
    };

    state_t      state_reg, state_next;
    issue_t      issue_reg, issue_next;
    logic [31:0] pc_reg;

    logic        src_valid;
    logic [31:0] src_inst;
    logic [31:0] src_pc;
    logic        adv;
    logic        hazard;
    logic        take;
    logic        stall_go;

    // decoded fields of the source instruction
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [7:0]  d_alu_op, d_mem_op;
    logic        d_load, d_store, d_a_pc;
    logic [31:0] d_opr1, d_opr2, d_store_data, d_br_target;
    logic        d_has_rd, d_br_en, d_jmp_en, d_illegal;
    logic        d_uses_rs1, d_uses_rs2;
    logic [2:0]  d_br_type;

    // the issue register may take a new entry when it is empty or being consumed
    assign adv = ~issue_reg.valid | out_ready;

`ifdef DECODE_ISSUE_SKID_EN
    logic        skid_full_reg;
    logic [31:0] skid_inst_reg;
    logic [31:0] skid_pc_reg;

    // a parked instruction always drains before anything new is presented
    assign src_valid  = skid_full_reg | inst_valid;
    assign src_inst   = skid_full_reg ? skid_inst_reg : inst;
    assign src_pc     = skid_full_reg ? skid_pc_reg : inst_pc;
    assign inst_ready = ~skid_full_reg;
    assign take       = src_valid & adv & ~hazard;

    // skid entry: park an accepted instruction that cannot issue this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_full_reg <= 1'b0;
            skid_inst_reg <= 32'd0;
            skid_pc_reg   <= 32'd0;
        end else if (flush) begin
            skid_full_reg <= 1'b0;
        end else if (skid_full_reg) begin
            if (take) begin
                skid_full_reg <= 1'b0;
            end
        end else if (inst_valid && !take) begin
            skid_full_reg <= 1'b1;
            skid_inst_reg <= inst;
            skid_pc_reg   <= inst_pc;
        end
    end
`else
    assign src_valid  = inst_valid;
    assign src_inst   = inst;
    assign src_pc     = inst_pc;
    assign inst_ready = adv & ~hazard;
    assign take       = inst_valid & inst_ready;
`endif

    assign opcode   = src_inst[6:0];
    assign f3       = src_inst[14:12];
    assign f7       = src_inst[31:25];
    assign rd_f     = src_inst[11:7];
    assign rs1_addr = src_inst[19:15];
    assign rs2_addr = src_inst[24:20];

    assign imm_i = {{20{src_inst[31]}}, src_inst[31:20]};
    assign imm_s = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
    assign imm_b = {{19{src_inst[31]}}, src_inst[31], src_inst[7], src_inst[30:25], src_inst[11:8], 1'b0};
    assign imm_u = {src_inst[31:12], 12'd0};
    assign imm_j = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12], src_inst[20], src_inst[30:21], 1'b0};

    // Load-use: the load in the issue register cannot forward, so a reader of
    // its rd waits one cycle. Nothing can collide while the bubble is held.
    assign hazard = (state_reg == RUN) & issue_reg.valid & ~issue_reg.load & issue_reg.wb_en &
                    ((d_uses_rs1 & (rs1_addr == issue_reg.rd)) |
                     (d_uses_rs2 & (rs2_addr == issue_reg.rd)));

    assign stall_go = hazard & src_valid & adv & ~flush;

    // instruction decode into active-low controls, operands and branch info
    always_comb begin
        d_alu_op     = ALU_NOP;
        d_mem_op     = MEM_NOP;
        d_load       = 1'b1;
        d_store      = 1'b1;
        d_a_pc       = 1'b0;
        d_opr1       = rs1_data;
        d_opr2       = 32'd0;
        d_store_data = 32'd0;
        d_has_rd     = 1'b0;
        d_br_type    = 3'd0;
        d_br_en      = 1'b0;
        d_jmp_en     = 1'b0;
        d_br_target  = 32'd0;
        d_illegal    = 1'b0;
        d_uses_rs1   = 1'b0;
        d_uses_rs2   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d_alu_op = ALU_ADD;
                d_opr1   = 32'd0;
                d_opr2   = imm_u;
                d_has_rd = 1'b1;
            end
            OPC_AUIPC: begin
                d_alu_op = ALU_ADD;
                d_a_pc   = 1'b1;
                d_opr1   = 32'd0;
                d_opr2   = imm_u;
                d_has_rd = 1'b1;
            end
            OPC_JAL: begin
                d_alu_op    = ALU_ADD;
                d_a_pc      = 1'b1;
                d_opr1      = 32'd0;
                d_opr2      = 32'd4;
                d_has_rd    = 1'b1;
                d_jmp_en    = 1'b1;
                d_br_target = src_pc + imm_j;
            end
            OPC_JALR: begin
                d_uses_rs1  = 1'b1;
                d_alu_op    = ALU_ADD;
                d_a_pc      = 1'b1;
                d_opr1      = 32'd0;
                d_opr2      = 32'd4;
                d_has_rd    = 1'b1;
                d_jmp_en    = 1'b1;
                d_br_target = (rs1_data + imm_i) & 32'hFFFF_FFFE;
                d_illegal   = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                d_uses_rs1  = 1'b1;
                d_uses_rs2  = 1'b1;
                d_alu_op    = ALU_SUB;
                d_opr2      = rs2_data;
                d_br_en     = 1'b1;
                d_br_type   = f3;
                d_br_target = src_pc + imm_b;
                d_illegal   = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                d_uses_rs1 = 1'b1;
                d_alu_op   = ALU_ADD;
                d_opr2     = imm_i;
                d_load     = 1'b0;
                d_has_rd   = 1'b1;
                case (f3)
                    3'b000:  d_mem_op = MEM_LB;
                    3'b001:  d_mem_op = MEM_LH;
                    3'b010:  d_mem_op = MEM_LW;
                    3'b100:  d_mem_op = MEM_LBU;
                    3'b101:  d_mem_op = MEM_LHU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                d_uses_rs1   = 1'b1;
                d_uses_rs2   = 1'b1;
                d_alu_op     = ALU_ADD;
                d_opr2       = imm_s;
                d_store      = 1'b0;
                d_store_data = rs2_data;
                case (f3)
                    3'b000:  d_mem_op = MEM_SB;
                    3'b001:  d_mem_op = MEM_SH;
                    3'b010:  d_mem_op = MEM_SW;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                d_uses_rs1 = 1'b1;
                d_has_rd   = 1'b1;
                d_opr2     = imm_i;
                case (f3)
                    3'b000: d_alu_op = ALU_ADD;
                    3'b010: d_alu_op = ALU_SLT;
                    3'b011: d_alu_op = ALU_SLTU;
                    3'b100: d_alu_op = ALU_XOR;
                    3'b110: d_alu_op = ALU_OR;
                    3'b111: d_alu_op = ALU_AND;
                    3'b001: begin
                        // shift amount only; the upper immediate bits are funct7
                        d_opr2 = {27'd0, imm_i[4:0]};
                        if (f7 == 7'b0000000) d_alu_op = ALU_SLL;
                        else                  d_illegal = 1'b1;
                    end
                    default: begin
                        d_opr2 = {27'd0, imm_i[4:0]};
                        if (f7 == 7'b0000000)      d_alu_op = ALU_SRL;
                        else if (f7 == 7'b0100000) d_alu_op = ALU_SRA;
                        else                       d_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                d_uses_rs1 = 1'b1;
                d_uses_rs2 = 1'b1;
                d_has_rd   = 1'b1;
                d_opr2     = rs2_data;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d_alu_op = ALU_ADD;
                        3'b001:  d_alu_op = ALU_SLL;
                        3'b010:  d_alu_op = ALU_SLT;
                        3'b011:  d_alu_op = ALU_SLTU;
                        3'b100:  d_alu_op = ALU_XOR;
                        3'b101:  d_alu_op = ALU_SRL;
                        3'b110:  d_alu_op = ALU_OR;
                        default: d_alu_op = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d_alu_op = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d_alu_op = ALU_SRA;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            default: d_illegal = 1'b1;
        endcase
    end

    // next issue-register contents: decoded entry, illegal marker or bubble
    always_comb begin
        issue_next = ISSUE_BUBBLE;
        if (take && !flush) begin
            issue_next.valid = 1'b1;
            if (d_illegal) begin
                issue_next.illegal = 1'b1;
            end else begin
                issue_next.alu_op     = d_alu_op;
                issue_next.mem_op     = d_mem_op;
                issue_next.load       = d_load;
                issue_next.store      = d_store;
                issue_next.a_pc       = d_a_pc;
                issue_next.opr1       = d_opr1;
                issue_next.opr2       = d_opr2;
                issue_next.store_data = d_store_data;
                issue_next.rd         = d_has_rd ? rd_f : 5'd0;
                issue_next.wb_en      = d_has_rd & (rd_f != 5'd0);
                issue_next.br_type    = d_br_type;
                issue_next.br_en      = d_br_en;
                issue_next.jmp_en     = d_jmp_en;
                issue_next.br_target  = d_br_target;
            end
        end
    end

    // issue register: loads when it can advance; flush kills it even when held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_reg <= ISSUE_BUBBLE;
            pc_reg    <= RESET_PC;
        end else if (flush || adv) begin
            issue_reg <= issue_next;
            if (take && !flush) begin
                pc_reg <= src_pc;
            end
        end
    end

    // interlock state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // STALL marks the cycle the interlock bubble sits in the issue register
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = RUN;
        end else begin
            case (state_reg)
                RUN:     if (stall_go) state_next = STALL;
                STALL:   state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    assign out_valid  = issue_reg.valid;
    assign alu_op     = issue_reg.alu_op;
    assign mem_op     = issue_reg.mem_op;
    assign load       = issue_reg.load;
    assign store      = issue_reg.store;
    assign alu_opr_1  = issue_reg.a_pc ? pc_reg : issue_reg.opr1;
    assign alu_opr_2  = issue_reg.opr2;
    assign store_data = issue_reg.store_data;
    assign rd         = issue_reg.rd;
    assign wb_en      = issue_reg.wb_en;
    assign br_type    = issue_reg.br_type;
    assign br_en      = issue_reg.br_en;
    assign jmp_en     = issue_reg.jmp_en;
    assign br_target  = issue_reg.br_target;
    assign illegal    = issue_reg.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed vectors with hand-computed expectations for decode_issue.
module tb_decode_issue;

    logic        clk;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  alu_op;
    logic [7:0]  mem_op;
    logic        load;
    logic        store;
    logic [31:0] alu_opr_1;
    logic [31:0] alu_opr_2;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        wb_en;
    logic [2:0]  br_type;
    logic        br_en;
    logic        jmp_en;
    logic [31:0] br_target;
    logic        illegal;

    int checks_cnt = 0;
    int errors_cnt = 0;

    decode_issue dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_op     (alu_op),
        .mem_op     (mem_op),
        .load       (load),
        .store      (store),
        .alu_opr_1  (alu_opr_1),
        .alu_opr_2  (alu_opr_2),
        .store_data (store_data),
        .rd         (rd),
        .wb_en      (wb_en),
        .br_type    (br_type),
        .br_en      (br_en),
        .jmp_en     (jmp_en),
        .br_target  (br_target),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] i, input logic [31:0] pc,
                           input logic [31:0] r1, input logic [31:0] r2);
        inst       = i;
        inst_pc    = pc;
        rs1_data   = r1;
        rs2_data   = r2;
        inst_valid = 1'b1;
    endtask

    task automatic check_bubble_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_alu"}, alu_op, 8'hFF);
        check({tag, "_mem"}, mem_op, 8'hFF);
        check({tag, "_load"}, load, 1);
        check({tag, "_store"}, store, 1);
        check({tag, "_a"}, alu_opr_1, 0);
        check({tag, "_b"}, alu_opr_2, 0);
        check({tag, "_sdata"}, store_data, 0);
        check({tag, "_tgt"}, br_target, 0);
        check({tag, "_rd"}, rd, 0);
        check({tag, "_wb"}, wb_en, 0);
        check({tag, "_bren"}, br_en, 0);
        check({tag, "_jmp"}, jmp_en, 0);
        check({tag, "_ill"}, illegal, 0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [7:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wb;
    } alu_vec_t;

    alu_vec_t alu_vecs[6];

    initial begin
        alu_vecs[0] = '{"addi",  32'h00500093, 32'h0,     32'h0, 8'hFB, 32'h0,  32'h5,        5'd1,  1'b1};
        alu_vecs[1] = '{"slt",   32'h0020A1B3, 32'h3,     32'h9, 8'h7A, 32'h3,  32'h9,        5'd3,  1'b1};
        alu_vecs[2] = '{"srai",  32'h4030D213, 32'h80,    32'h0, 8'hF3, 32'h80, 32'h3,        5'd4,  1'b1};
        alu_vecs[3] = '{"sltiu", 32'hFFF0B293, 32'h1,     32'h0, 8'hBA, 32'h1,  32'hFFFFFFFF, 5'd5,  1'b1};
        alu_vecs[4] = '{"lui",   32'h12345537, 32'hAAAA,  32'h0, 8'hFB, 32'h0,  32'h12345000, 5'd10, 1'b1};
        alu_vecs[5] = '{"addx0", 32'h00208033, 32'h1,     32'h2, 8'hFB, 32'h1,  32'h2,        5'd0,  1'b0};

        rst        = 1'b1;
        inst_valid = 1'b0;
        inst       = 32'd0;
        inst_pc    = 32'd0;
        rs1_data   = 32'd0;
        rs2_data   = 32'd0;
        flush      = 1'b0;
        out_ready  = 1'b1;

        // reset values
        tick();
        tick();
        check_bubble_outputs("reset");
        rst = 1'b0;
        tick();
        check("idle_valid", out_valid, 0);
        $display("txn reset: outputs at reset values, idle keeps out_valid low");

        // ALU decode table, issued back to back
        foreach (alu_vecs[k]) begin
            present(alu_vecs[k].inst, 32'h0, alu_vecs[k].r1, alu_vecs[k].r2);
            #1;
            check({alu_vecs[k].name, "_rdy"}, inst_ready, 1);
            tick();
            check({alu_vecs[k].name, "_valid"}, out_valid, 1);
            check({alu_vecs[k].name, "_alu"}, alu_op, alu_vecs[k].alu);
            check({alu_vecs[k].name, "_a"}, alu_opr_1, alu_vecs[k].a);
            check({alu_vecs[k].name, "_b"}, alu_opr_2, alu_vecs[k].b);
            check({alu_vecs[k].name, "_rd"}, rd, alu_vecs[k].rd);
            check({alu_vecs[k].name, "_wb"}, wb_en, alu_vecs[k].wb);
            check({alu_vecs[k].name, "_mem"}, mem_op, 8'hFF);
            check({alu_vecs[k].name, "_ld"}, load, 1);
            check({alu_vecs[k].name, "_st"}, store, 1);
            $display("txn %s: inst=%h alu_op=%h A=%h B=%h rd=%0d", alu_vecs[k].name,
                     alu_vecs[k].inst, alu_op, alu_opr_1, alu_opr_2, rd);
        end

        // sw x2,8(x3)
        present(32'h0021A423, 32'h0, 32'h100, 32'hDEADBEEF);
        #1;
        check("sw_rs1addr", rs1_addr, 3);
        check("sw_rs2addr", rs2_addr, 2);
        tick();
        check("sw_mem", mem_op, 8'hFE);
        check("sw_store", store, 0);
        check("sw_load", load, 1);
        check("sw_a", alu_opr_1, 32'h100);
        check("sw_b", alu_opr_2, 32'h8);
        check("sw_sdata", store_data, 32'hDEADBEEF);
        check("sw_wb", wb_en, 0);
        $display("txn sw: mem_op=%h store=%b store_data=%h", mem_op, store, store_data);

        // lw x5,0(x1) followed by add x6,x5,x5
        present(32'h0000A283, 32'h0, 32'h200, 32'h0);
        tick();
        check("lw_mem", mem_op, 8'hDF);
        check("lw_load", load, 0);
        check("lw_rd", rd, 5);
        check("lw_a", alu_opr_1, 32'h200);
        present(32'h00528333, 32'h0, 32'h7, 32'h7);
        #1;
        check("lu_rdy_hazard", inst_ready, 0);
        tick();
        check("lu_bubble_valid", out_valid, 0);
        #1;
        check("lu_rdy_after", inst_ready, 1);
        tick();
        check("lu_add_valid", out_valid, 1);
        check("lu_add_alu", alu_op, 8'hFB);
        check("lu_add_rd", rd, 6);
        check("lu_add_a", alu_opr_1, 32'h7);
        check("lu_add_b", alu_opr_2, 32'h7);
        $display("txn load-use: one bubble, add issued with rd=%0d", rd);
        inst_valid = 1'b0;
        tick();

        // backpressure: ori x7,x2,0xF0 held for 3 cycles while sub waits
        out_ready = 1'b0;
        present(32'h0F016393, 32'h0, 32'h1234, 32'h0);
        #1;
        check("bp_rdy_empty", inst_ready, 1);
        tick();
        present(32'h40208433, 32'h0, 32'h50, 32'h8);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_rdy_hold", inst_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_alu", alu_op, 8'hFD);
            check("bp_hold_a", alu_opr_1, 32'h1234);
            check("bp_hold_b", alu_opr_2, 32'hF0);
            check("bp_hold_rd", rd, 7);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_rdy_release", inst_ready, 1);
        tick();
        check("bp_sub_alu", alu_op, 8'hFA);
        check("bp_sub_a", alu_opr_1, 32'h50);
        check("bp_sub_b", alu_opr_2, 32'h8);
        check("bp_sub_rd", rd, 8);
        $display("txn backpressure: ori held 3 cycles, sub issued afterwards");

        // asynchronous reset while the issue register is held
        inst_valid = 1'b0;
        out_ready  = 1'b0;
        tick();
        rst = 1'b1;
        #2;
        check_bubble_outputs("rst_hold");
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        $display("txn reset mid-hold: outputs returned to reset values without a clock edge");

        // flush with a concurrent transfer
        present(32'h00500093, 32'h0, 32'h0, 32'h0);
        tick();
        check("fl_pre_valid", out_valid, 1);
        present(32'h00100493, 32'h0, 32'h0, 32'h0);
        flush = 1'b1;
        tick();
        flush      = 1'b0;
        inst_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        tick();
        check("fl_after_valid", out_valid, 0);
        check("fl_after_rd", rd, 0);
        $display("txn flush: issue register killed, concurrent addi x9 discarded");

        // blt x1,x2,-16 at pc 0x40
        present(32'hFE20C8E3, 32'h40, 32'h5, 32'h6);
        tick();
        check("blt_bren", br_en, 1);
        check("blt_type", br_type, 3'b100);
        check("blt_tgt", br_target, 32'h30);
        check("blt_alu", alu_op, 8'hFA);
        check("blt_jmp", jmp_en, 0);
        check("blt_wb", wb_en, 0);
        check("blt_a", alu_opr_1, 32'h5);
        check("blt_b", alu_opr_2, 32'h6);
        $display("txn blt: br_target=%h br_type=%b", br_target, br_type);

        // jal x1,+8 at pc 0x100
        present(32'h008000EF, 32'h100, 32'h0, 32'h0);
        tick();
        check("jal_jmp", jmp_en, 1);
        check("jal_bren", br_en, 0);
        check("jal_a", alu_opr_1, 32'h100);
        check("jal_b", alu_opr_2, 32'h4);
        check("jal_tgt", br_target, 32'h108);
        check("jal_rd", rd, 1);
        check("jal_wb", wb_en, 1);
        $display("txn jal: A=%h B=%h br_target=%h", alu_opr_1, alu_opr_2, br_target);

        // unsupported opcode 0x7F
        present(32'h0000007F, 32'h0, 32'h0, 32'h0);
        tick();
        check("ill_flag", illegal, 1);
        check("ill_valid", out_valid, 1);
        check("ill_alu", alu_op, 8'hFF);
        check("ill_wb", wb_en, 0);
        inst_valid = 1'b0;
        tick();
        check("ill_clear", illegal, 0);
        check("ill_clear_valid", out_valid, 0);
        $display("txn illegal: flagged for one valid cycle");

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
